// File: rtl/serial_sub.sv
// Bit-serial W-bit subtractor D = A - B, LSB first, one bit per clock, with start/done handshake.
// Optional signed overflow output o_ovf is enabled by defining SERIAL_SUB_OVF_EN.
module serial_sub #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_start,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic         o_busy,
    output logic         o_done,
    output logic [W-1:0] o_d,
    output logic         o_bo
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic         o_ovf
`endif
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } state_t;

    state_t          r_state;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [W-1:0]    r_d;
    logic [CW-1:0]   r_cnt;
    logic            r_br;
    logic            r_bo;
    logic            r_busy;
    logic            r_done;
`ifdef SERIAL_SUB_OVF_EN
    logic            r_ovf;
`endif

    logic w_a0;
    logic w_b0;
    logic w_dbit;
    logic w_brNext;
    logic w_last;

    // One full-subtractor cell fed from the operand LSBs and the borrow flop.
    assign w_a0     = r_a[0];
    assign w_b0     = r_b[0];
    assign w_dbit   = w_a0 ^ w_b0 ^ r_br;
    assign w_brNext = (~w_a0 & w_b0) | (~(w_a0 ^ w_b0) & r_br);
    assign w_last   = (r_cnt == CW'(W - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_d     <= '0;
            r_cnt   <= '0;
            r_br    <= 1'b0;
            r_bo    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            r_ovf   <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE, FIN: begin
                    r_done <= 1'b0;
                    if (i_start) begin
                        r_a     <= i_a;
                        r_b     <= i_b;
                        r_br    <= 1'b0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    r_d   <= {w_dbit, r_d[W-1:1]};
                    r_a   <= {1'b0, r_a[W-1:1]};
                    r_b   <= {1'b0, r_b[W-1:1]};
                    r_br  <= w_brNext;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        // On the last bit the LSBs hold the operand sign bits and dbit is the result sign.
                        r_bo    <= w_brNext;
`ifdef SERIAL_SUB_OVF_EN
                        r_ovf   <= (w_a0 != w_b0) && (w_dbit != w_a0);
`endif
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= FIN;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_d    = r_d;
    assign o_bo   = r_bo;
`ifdef SERIAL_SUB_OVF_EN
    assign o_ovf  = r_ovf;
`endif

endmodule

// File: tb/tb_serial_sub.sv
// Directed self-checking bench for serial_sub (W=8) with hand-computed results.
// Covers reset, basic subtraction, ignored START while busy, back-to-back runs and mid-operation reset.
module tb_serial_sub;

    logic       clk;
    logic       rstN;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic [7:0] d;
    logic       bo;
`ifdef SERIAL_SUB_OVF_EN
    logic       ovf;
`endif

    int checkCount = 0;
    int passCount  = 0;

    serial_sub #(.W(8)) dut (
        .i_clk   (clk),
        .i_rst_n (rstN),
        .i_start (start),
        .i_a     (a),
        .i_b     (b),
        .o_busy  (busy),
        .o_done  (done),
        .o_d     (d),
        .o_bo    (bo)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .o_ovf   (ovf)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Issue one single-cycle START and watch until DONE; doneCyc is 0 if DONE never arrives.
    task automatic runOp(input logic [7:0] opA, input logic [7:0] opB,
                         output int doneCyc, output int busyCyc);
        doneCyc = 0;
        busyCyc = 0;
        @(negedge clk);
        a = opA;
        b = opB;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clk);
            if (busy) busyCyc++;
            if (done) begin
                doneCyc = cyc;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rstN  = 1'b1;
        start = 1'b0;
        a     = 8'h00;
        b     = 8'h00;
        #2 rstN = 1'b0;
        #3;
        checkCount++;
        if ({busy, done, bo, d} !== 11'h000)
            $display("[TB] FAIL reset_outputs: got busy=%b done=%b bo=%b d=%h, expected all 0", busy, done, bo, d);
        else passCount++;
`ifdef SERIAL_SUB_OVF_EN
        checkCount++;
        if (ovf !== 1'b0) $display("[TB] FAIL reset_ovf: got %b expected 0", ovf);
        else passCount++;
`endif
        repeat (2) @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);
        checkCount++;
        if (busy !== 1'b0 || done !== 1'b0)
            $display("[TB] FAIL idle_after_reset: got busy=%b done=%b expected 0 0", busy, done);
        else passCount++;
    endtask

    task automatic test_basic;
        logic [7:0] vecA [4] = '{8'h5A, 8'h10, 8'h00, 8'hC3};
        logic [7:0] vecB [4] = '{8'h23, 8'h20, 8'hFF, 8'hC3};
        logic [7:0] vecD [4] = '{8'h37, 8'hF0, 8'h01, 8'h00};
        logic       vecBo[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        int doneCyc;
        int busyCyc;
        for (int i = 0; i < 4; i++) begin
            runOp(vecA[i], vecB[i], doneCyc, busyCyc);
            checkCount++;
            if (doneCyc !== 9) $display("[TB] FAIL basic%0d_latency: got %0d expected 9", i, doneCyc);
            else passCount++;
            checkCount++;
            if (busyCyc !== 8) $display("[TB] FAIL basic%0d_busy_cycles: got %0d expected 8", i, busyCyc);
            else passCount++;
            checkCount++;
            if (d !== vecD[i]) $display("[TB] FAIL basic%0d_d: got %h expected %h", i, d, vecD[i]);
            else passCount++;
            checkCount++;
            if (bo !== vecBo[i]) $display("[TB] FAIL basic%0d_bo: got %b expected %b", i, bo, vecBo[i]);
            else passCount++;
            @(negedge clk);
            checkCount++;
            if (done !== 1'b0 || d !== vecD[i])
                $display("[TB] FAIL basic%0d_hold: got done=%b d=%h expected 0 %h", i, done, d, vecD[i]);
            else passCount++;
        end
    endtask

`ifdef SERIAL_SUB_OVF_EN
    task automatic test_ovf;
        logic [7:0] vecA  [3] = '{8'h80, 8'h7F, 8'h05};
        logic [7:0] vecB  [3] = '{8'h01, 8'hFF, 8'h03};
        logic [7:0] vecD  [3] = '{8'h7F, 8'h80, 8'h02};
        logic       vecBo [3] = '{1'b0, 1'b1, 1'b0};
        logic       vecOvf[3] = '{1'b1, 1'b1, 1'b0};
        int doneCyc;
        int busyCyc;
        for (int i = 0; i < 3; i++) begin
            runOp(vecA[i], vecB[i], doneCyc, busyCyc);
            checkCount++;
            if (doneCyc !== 9 || d !== vecD[i] || bo !== vecBo[i] || ovf !== vecOvf[i])
                $display("[TB] FAIL ovf%0d: got cyc=%0d d=%h bo=%b ovf=%b expected 9 %h %b %b",
                         i, doneCyc, d, bo, ovf, vecD[i], vecBo[i], vecOvf[i]);
            else passCount++;
        end
    endtask
`endif

    task automatic test_busy_ignore;
        int doneCount = 0;
        logic [7:0] dAtDone = 8'h00;
        @(negedge clk);
        a = 8'h09;
        b = 8'h02;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        a = 8'h44;
        b = 8'h11;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc < 25; cyc++) begin
            @(negedge clk);
            if (done) begin
                doneCount++;
                dAtDone = d;
            end
        end
        checkCount++;
        if (doneCount !== 1) $display("[TB] FAIL ignore_done_count: got %0d expected 1", doneCount);
        else passCount++;
        checkCount++;
        if (dAtDone !== 8'h07) $display("[TB] FAIL ignore_d: got %h expected 07", dAtDone);
        else passCount++;
    endtask

    task automatic test_back_to_back;
        logic [7:0] vecA [3] = '{8'h01, 8'h20, 8'h03};
        logic [7:0] vecB [3] = '{8'h01, 8'h05, 8'h04};
        logic [7:0] vecD [3] = '{8'h00, 8'h1B, 8'hFF};
        logic       vecBo[3] = '{1'b0, 1'b0, 1'b1};
        int idx = 0;
        int lastCyc = 0;
        int cyc = 0;
        @(negedge clk);
        a = vecA[0];
        b = vecB[0];
        start = 1'b1;
        while (idx < 3 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                checkCount++;
                if ((cyc - lastCyc) !== 9)
                    $display("[TB] FAIL b2b%0d_spacing: got %0d expected 9", idx, cyc - lastCyc);
                else passCount++;
                checkCount++;
                if (d !== vecD[idx] || bo !== vecBo[idx])
                    $display("[TB] FAIL b2b%0d_result: got d=%h bo=%b expected %h %b",
                             idx, d, bo, vecD[idx], vecBo[idx]);
                else passCount++;
                lastCyc = cyc;
                idx++;
                if (idx < 3) begin
                    a = vecA[idx];
                    b = vecB[idx];
                end else begin
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        checkCount++;
        if (idx !== 3) $display("[TB] FAIL b2b_timeout: got %0d results expected 3", idx);
        else passCount++;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_abort;
        int doneCount = 0;
        int doneCyc;
        int busyCyc;
        @(negedge clk);
        a = 8'h5A;
        b = 8'h23;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(negedge clk);
        rstN = 1'b0;
        #1;
        checkCount++;
        if ({busy, done, bo, d} !== 11'h000)
            $display("[TB] FAIL abort_outputs: got busy=%b done=%b bo=%b d=%h, expected all 0", busy, done, bo, d);
        else passCount++;
        @(negedge clk);
        rstN = 1'b1;
        for (int cyc = 0; cyc < 15; cyc++) begin
            @(negedge clk);
            if (done || busy) doneCount++;
        end
        checkCount++;
        if (doneCount !== 0) $display("[TB] FAIL abort_no_done: got %0d active cycles expected 0", doneCount);
        else passCount++;
        runOp(8'h10, 8'h01, doneCyc, busyCyc);
        checkCount++;
        if (doneCyc !== 9 || d !== 8'h0F || bo !== 1'b0)
            $display("[TB] FAIL abort_recover: got cyc=%0d d=%h bo=%b expected 9 0f 0", doneCyc, d, bo);
        else passCount++;
    endtask

    initial begin
        test_reset();
        test_basic();
`ifdef SERIAL_SUB_OVF_EN
        test_ovf();
`endif
        test_busy_ignore();
        test_back_to_back();
        test_reset_abort();
        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/serial_sub.md
Name: serial_sub

Overview:
- Bit-serial N-bit subtractor D = A - B, LSB first, one bit per clock.
- Uses one full-subtractor cell (difference = a^b^bin, borrow chain), the inverse arithmetic direction of the combinational full-adder cell in the arithmetic library.
- Sits beside the adder datapath where area matters more than latency.
- Start/done handshake toward a controlling FSM; result held until the next start.

Parameters:
- W, 8, operand and result width in bits (W >= 2).

Ports:
- CLK  input  1  rising-edge clock
- RST_N  input  1  asynchronous active-low reset
- START  input  1  request; sampled only while not BUSY
- A  input  W  minuend; sampled at accepted START
- B  input  W  subtrahend; sampled at accepted START
- BUSY  output  1  high while bits are being processed
- DONE  output  1  one-cycle pulse when D/BO become valid
- D  output  W  difference A - B mod 2^W; held after DONE
- BO  output  1  final borrow; 1 iff A < B unsigned

Behaviour:
- Reset is asynchronous on RST_N low. Reset values: BUSY=0, DONE=0, D=0, BO=0, state=IDLE, bit counter=0, internal borrow=0.
- States: IDLE, RUN, FIN.
- IDLE, or FIN, with START=1:
  - load A and B into shift registers; clear the borrow flop and the counter.
  - go to RUN. BUSY=1 from the next cycle.
- RUN, each cycle:
  - a0 = LSB of the A register; b0 = LSB of the B register; br = borrow flop.
  - dbit = a0^b0^br.
  - br_next = (~a0&b0) | (~(a0^b0)&br).
  - Shift dbit into the D register at the MSB. Shift the A and B registers right.
  - Increment the counter.
- After the W-th RUN cycle (counter == W-1): go to FIN.
  - D and BO are updated with the final bit and borrow in the same edge.
- FIN: DONE=1 for exactly one cycle, BUSY=0. Then go to IDLE unless START=1, which restarts immediately.
- D and BO update only during RUN.
- D register contents during RUN are partial results and not meaningful; consumers qualify D with DONE or with !BUSY.
- Latency: START accepted at edge k; DONE high in the cycle after edge k+W; throughput one operation per W+1 cycles.
- START while BUSY: ignored; it does not queue. A and B changes while BUSY have no effect.
- START held high continuously: back-to-back operations, each sampling A/B at its own accept edge.
- A == B: D=0, BO=0.
- A=0, B=2^W-1: D=1, BO=1. The wrap-around is the modulo result.
- RST_N low mid-operation: the operation is aborted, all outputs return to reset values, and no DONE is issued.

Optional Feature:
- Macro SERIAL_SUB_OVF_EN.
- Defined:
  - adds output port OVF (1 bit, reset 0), the signed two's-complement overflow of A - B.
  - OVF = (A[W-1] != B[W-1]) && (D[W-1] != A[W-1]), using the sampled operands.
  - OVF is registered with the final RUN edge and held like D.
- Undefined: no OVF port and no associated logic. All other behaviour is identical.

Test Plan:
- W=8, A=0x5A, B=0x23, START 1 cycle -> BUSY for 8 cycles; DONE pulse at cycle 9 after accept; D=0x37, BO=0.
- A=0x10, B=0x20 -> D=0xF0, BO=1; A=0x00, B=0xFF -> D=0x01, BO=1; A=B=0xC3 -> D=0x00, BO=0.
- With SERIAL_SUB_OVF_EN: A=0x80, B=0x01 -> D=0x7F, OVF=1, BO=0. Then A=0x7F, B=0xFF -> D=0x80, OVF=1, BO=1. Then A=0x05, B=0x03 -> OVF=0.
- START pulsed with A=0x44, B=0x11 while BUSY from A=0x09, B=0x02 -> second request ignored; one DONE only; D=0x07.
- START held high, operands changed at each accept -> DONE every 9 cycles with correct D each time.
- RST_N low for 1 cycle at bit 4 of an operation -> outputs 0, no DONE. A new START then completes normally.
